// File: rtl/nv_nvdla_sdp_slcg_ctrl.sv
// Per-channel SLCG sequencer for the SDP read-DMA clock gates.
// Each channel runs an OFF/WAKE/ON/HOLD handshake FSM that drives the clk_en
// of its NV_CLK_gate_power instance. Wake-up delay and idle hysteresis keep
// the gated clocks from toggling on every transaction. Overrides force all
// gates open without disturbing the FSMs.
// Optional build macro NVDLA_SDP_SLCG_STAT_EN adds per-channel gated-cycle
// statistics counters (stat_clr input, gated_cyc output).
module nv_nvdla_sdp_slcg_ctrl #(
  parameter int NUM_CH   = 4,
  parameter int WAKE_CYC = 2,
  parameter int HOLD_CYC = 16,
  parameter int CNT_W    = 8
) (
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rstn,
  input  logic                 dla_clk_ovr_on_sync,
  input  logic                 global_clk_ovr_on_sync,
  input  logic                 tmc2slcg_disable_clock_gating,
  input  logic [NUM_CH-1:0]    gate_dis,
  input  logic [NUM_CH-1:0]    req,
`ifdef NVDLA_SDP_SLCG_STAT_EN
  input  logic                 stat_clr,
  output logic [NUM_CH*16-1:0] gated_cyc,
`endif
  output logic [NUM_CH-1:0]    ack,
  output logic [NUM_CH-1:0]    clk_en
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t                  state     [NUM_CH];
  state_t                  state_nxt [NUM_CH];
  logic [CNT_W-1:0]        cnt       [NUM_CH];
  logic [CNT_W-1:0]        cnt_nxt   [NUM_CH];
  logic [NUM_CH-1:0]       force_on;
  logic                    ovr_any;

  assign ovr_any  = dla_clk_ovr_on_sync | global_clk_ovr_on_sync |
                    tmc2slcg_disable_clock_gating;
  assign force_on = {NUM_CH{ovr_any}} | gate_dis;

  // Next-state and countdown logic, one independent FSM per channel.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = cnt[i];
      case (state[i])
        ST_OFF: begin
          if (req[i]) begin
            if (force_on[i]) begin
              state_nxt[i] = ST_ON;
            end else begin
              state_nxt[i] = ST_WAKE;
              cnt_nxt[i]   = WAKE_LD;
            end
          end
        end
        ST_WAKE: begin
          // Wake always runs to completion, even if req drops or force rises.
          if (cnt[i] != '0) begin
            cnt_nxt[i] = cnt[i] - CNT_ONE;
          end else begin
            state_nxt[i] = ST_ON;
          end
        end
        ST_ON: begin
          if (!req[i]) begin
            state_nxt[i] = ST_HOLD;
            cnt_nxt[i]   = HOLD_LD;
          end
        end
        ST_HOLD: begin
          if (req[i]) begin
            state_nxt[i] = ST_ON;
          end else if (cnt[i] == '0) begin
            state_nxt[i] = ST_OFF;
          end else begin
            cnt_nxt[i] = cnt[i] - CNT_ONE;
          end
        end
        default: begin
          state_nxt[i] = ST_OFF;
        end
      endcase
    end
  end

  // State, counter and registered gate-control outputs.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state[i] <= ST_OFF;
        cnt[i]   <= '0;
      end
      clk_en <= '0;
      ack    <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state[i]  <= state_nxt[i];
        cnt[i]    <= cnt_nxt[i];
        clk_en[i] <= (state_nxt[i] != ST_OFF) | force_on[i];
        ack[i]    <= (state_nxt[i] == ST_ON);
      end
    end
  end

`ifdef NVDLA_SDP_SLCG_STAT_EN
  logic [15:0] stat_cnt [NUM_CH];

  // Saturating count of cycles each channel spent with its clock gated.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        stat_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (stat_clr) begin
          stat_cnt[i] <= '0;
        end else if (!clk_en[i] && (stat_cnt[i] != 16'hFFFF)) begin
          stat_cnt[i] <= stat_cnt[i] + 16'd1;
        end
      end
    end
  end

  // Flatten the per-channel counters onto the output bus.
  always_comb begin
    gated_cyc = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      gated_cyc[i*16 +: 16] = stat_cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_nv_nvdla_sdp_slcg_ctrl.sv
// Directed self-checking bench for nv_nvdla_sdp_slcg_ctrl (default parameters).
module tb_nv_nvdla_sdp_slcg_ctrl;

  logic       clk;
  logic       rstn;
  logic       dla_ovr;
  logic       glb_ovr;
  logic       tmc_dis;
  logic [3:0] gate_dis;
  logic [3:0] req;
  logic [3:0] ack;
  logic [3:0] clk_en;
`ifdef NVDLA_SDP_SLCG_STAT_EN
  logic        stat_clr;
  logic [63:0] gated_cyc;
`endif

  int tests = 0;
  int fails = 0;

  nv_nvdla_sdp_slcg_ctrl #(
    .NUM_CH(4), .WAKE_CYC(2), .HOLD_CYC(16), .CNT_W(8)
  ) dut (
    .nvdla_core_clk               (clk),
    .nvdla_core_rstn              (rstn),
    .dla_clk_ovr_on_sync          (dla_ovr),
    .global_clk_ovr_on_sync       (glb_ovr),
    .tmc2slcg_disable_clock_gating(tmc_dis),
    .gate_dis                     (gate_dis),
    .req                          (req),
`ifdef NVDLA_SDP_SLCG_STAT_EN
    .stat_clr                     (stat_clr),
    .gated_cyc                    (gated_cyc),
`endif
    .ack                          (ack),
    .clk_en                       (clk_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset with all inputs idle; leaves the bench 1ns after an edge.
  task automatic do_reset();
    req      = '0;
    gate_dis = '0;
    dla_ovr  = 1'b0;
    glb_ovr  = 1'b0;
    tmc_dis  = 1'b0;
`ifdef NVDLA_SDP_SLCG_STAT_EN
    stat_clr = 1'b0;
`endif
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rstn = 1'b0;
    req  = 4'hF;
    tick();
    tick();
    tests++;
    if (clk_en !== 4'h0 || ack !== 4'h0) begin
      fails++;
      $display("FAIL reset_hold clk_en=%h ack=%h required 0/0", clk_en, ack);
    end
    rstn = 1'b1;
    tick();
    tests++;
    if (clk_en !== 4'hF || ack !== 4'h0) begin
      fails++;
      $display("FAIL reset_edge1 clk_en=%h ack=%h required F/0", clk_en, ack);
    end
    tick();
    tests++;
    if (ack !== 4'h0) begin
      fails++;
      $display("FAIL reset_edge2 ack=%h required 0", ack);
    end
    tick();
    tests++;
    if (ack !== 4'hF || clk_en !== 4'hF) begin
      fails++;
      $display("FAIL reset_edge3 clk_en=%h ack=%h required F/F", clk_en, ack);
    end
    // Asynchronous reset mid-operation clears outputs without a clock edge.
    #2;
    rstn = 1'b0;
    #1;
    tests++;
    if (clk_en !== 4'h0 || ack !== 4'h0) begin
      fails++;
      $display("FAIL reset_async clk_en=%h ack=%h required 0/0", clk_en, ack);
    end
    req = 4'h0;
  endtask

  task automatic test_hold();
    logic early_low;
    do_reset();
    req[0] = 1'b1;
    for (int n = 1; n <= 5; n++) tick();
    tests++;
    if (ack[0] !== 1'b1) begin
      fails++;
      $display("FAIL hold_ack_up ack0=%b required 1", ack[0]);
    end
    req[0] = 1'b0;
    tick();
    tests++;
    if (ack[0] !== 1'b0 || clk_en[0] !== 1'b1) begin
      fails++;
      $display("FAIL hold_ack_drop ack0=%b clk_en0=%b required 0/1", ack[0], clk_en[0]);
    end
    early_low = 1'b0;
    for (int n = 2; n <= 16; n++) begin
      tick();
      if (clk_en[0] !== 1'b1) early_low = 1'b1;
    end
    tests++;
    if (early_low !== 1'b0) begin
      fails++;
      $display("FAIL hold_early_off early_low=%b required 0", early_low);
    end
    tick();
    tests++;
    if (clk_en[0] !== 1'b0 || ack[0] !== 1'b0) begin
      fails++;
      $display("FAIL hold_off_edge17 clk_en0=%b ack0=%b required 0/0", clk_en[0], ack[0]);
    end
  endtask

  task automatic test_rereq();
    logic dropped;
    do_reset();
    req[1] = 1'b1;
    for (int n = 1; n <= 4; n++) tick();
    req[1] = 1'b0;
    dropped = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (clk_en[1] !== 1'b1) dropped = 1'b1;
    end
    tests++;
    if (ack[1] !== 1'b0) begin
      fails++;
      $display("FAIL rereq_ack_low ack1=%b required 0", ack[1]);
    end
    req[1] = 1'b1;
    tick();
    if (clk_en[1] !== 1'b1) dropped = 1'b1;
    tests++;
    if (ack[1] !== 1'b1) begin
      fails++;
      $display("FAIL rereq_ack_back ack1=%b required 1", ack[1]);
    end
    tests++;
    if (dropped !== 1'b0) begin
      fails++;
      $display("FAIL rereq_clk_dropped dropped=%b required 0", dropped);
    end
  endtask

  task automatic test_override();
    do_reset();
    glb_ovr = 1'b1;
    tick();
    tests++;
    if (clk_en !== 4'hF || ack !== 4'h0) begin
      fails++;
      $display("FAIL ovr_on clk_en=%h ack=%h required F/0", clk_en, ack);
    end
    req[2] = 1'b1;
    tick();
    tests++;
    if (ack !== 4'h4) begin
      fails++;
      $display("FAIL ovr_fast_ack ack=%h required 4", ack);
    end
    glb_ovr = 1'b0;
    tick();
    tests++;
    if (clk_en !== 4'h4 || ack !== 4'h4) begin
      fails++;
      $display("FAIL ovr_release clk_en=%h ack=%h required 4/4", clk_en, ack);
    end
    // Per-channel software disable only affects its own channel.
    do_reset();
    gate_dis = 4'b0010;
    tick();
    tests++;
    if (clk_en !== 4'h2 || ack !== 4'h0) begin
      fails++;
      $display("FAIL gate_dis clk_en=%h ack=%h required 2/0", clk_en, ack);
    end
    gate_dis = 4'b0000;
    tmc_dis  = 1'b1;
    tick();
    tests++;
    if (clk_en !== 4'hF) begin
      fails++;
      $display("FAIL tmc_dis clk_en=%h required F", clk_en);
    end
    tmc_dis = 1'b0;
  endtask

  task automatic test_force_wake();
    do_reset();
    req[0] = 1'b1;
    tick();
    dla_ovr = 1'b1;
    tick();
    tests++;
    if (ack[0] !== 1'b0 || clk_en !== 4'hF) begin
      fails++;
      $display("FAIL wake_no_shortcut ack0=%b clk_en=%h required 0/F", ack[0], clk_en);
    end
    tick();
    tests++;
    if (ack !== 4'h1) begin
      fails++;
      $display("FAIL wake_complete ack=%h required 1", ack);
    end
    dla_ovr = 1'b0;
  endtask

  task automatic test_pulse();
    logic [3:0] ack_hist;
    do_reset();
    ack_hist = '0;
    req[3] = 1'b1;
    tick();
    ack_hist[0] = ack[3];
    req[3] = 1'b0;
    for (int n = 2; n <= 4; n++) begin
      tick();
      ack_hist[n-1] = ack[3];
    end
    tests++;
    if (ack_hist !== 4'b0100) begin
      fails++;
      $display("FAIL pulse_ack edges1..4=%b required 0100", ack_hist);
    end
    for (int n = 5; n <= 19; n++) tick();
    tests++;
    if (clk_en[3] !== 1'b1) begin
      fails++;
      $display("FAIL pulse_hold_edge19 clk_en3=%b required 1", clk_en[3]);
    end
    tick();
    tests++;
    if (clk_en !== 4'h0 || ack !== 4'h0) begin
      fails++;
      $display("FAIL pulse_off_edge20 clk_en=%h ack=%h required 0/0", clk_en, ack);
    end
  endtask

`ifdef NVDLA_SDP_SLCG_STAT_EN
  task automatic test_stat();
    do_reset();
    for (int n = 1; n <= 100; n++) tick();
    tests++;
    if (gated_cyc[15:0] < 16'd99 || gated_cyc[15:0] > 16'd101 ||
        gated_cyc[63:48] < 16'd99 || gated_cyc[63:48] > 16'd101) begin
      fails++;
      $display("FAIL stat_count ch0=%0d ch3=%0d required 100+-1",
               gated_cyc[15:0], gated_cyc[63:48]);
    end
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    tests++;
    if (gated_cyc !== 64'h0) begin
      fails++;
      $display("FAIL stat_clr gated_cyc=%h required 0", gated_cyc);
    end
    for (int n = 1; n <= 65540; n++) tick();
    tests++;
    if (gated_cyc[15:0] !== 16'hFFFF) begin
      fails++;
      $display("FAIL stat_sat ch0=%h required FFFF", gated_cyc[15:0]);
    end
  endtask
`endif

  initial begin
    rstn     = 1'b0;
    req      = '0;
    gate_dis = '0;
    dla_ovr  = 1'b0;
    glb_ovr  = 1'b0;
    tmc_dis  = 1'b0;
`ifdef NVDLA_SDP_SLCG_STAT_EN
    stat_clr = 1'b0;
`endif
    test_reset();
    test_hold();
    test_rereq();
    test_override();
    test_force_wake();
    test_pulse();
`ifdef NVDLA_SDP_SLCG_STAT_EN
    test_stat();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
